// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: round-robin arbiter sharing one UART transmitter among
// NREQ requesters. Grants one requester, latches its word, pulses TxNewData,
// then returns Ack on the transmitter's DoneTx rising edge.
// Ports: CLK_Baudin/RstArb (sync, active-high); Req/ReqData from requesters;
// Gnt/Ack/Err/Busy back to them; TxData/TxNewData/TxRst/DoneTx to the TX.
// Macro UART_TX_ARB_TIMEOUT_EN adds a watchdog that aborts a frame after
// TIMEOUT cycles with Err and a TxRst pulse; otherwise Err/TxRst are 0.
module uart_tx_arbiter #(
  parameter int SIZE    = 32,
  parameter int NREQ    = 4,
  parameter int TIMEOUT = 140
) (
  input  logic                 CLK_Baudin,
  input  logic                 RstArb,
  input  logic [NREQ-1:0]      Req,
  input  logic [NREQ*SIZE-1:0] ReqData,
  output logic [NREQ-1:0]      Gnt,
  output logic [NREQ-1:0]      Ack,
  output logic [NREQ-1:0]      Err,
  output logic                 Busy,
  output logic [SIZE-1:0]      TxData,
  output logic                 TxNewData,
  output logic                 TxRst,
  input  logic                 DoneTx
);

  localparam int PW = $clog2(NREQ);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WAIT_DONE = 2'd1,
    RELEASE   = 2'd2
  } state_t;

  state_t          state;
  state_t          state_nxt;
  logic [PW-1:0]   ptr;
  logic [PW-1:0]   sel;
  logic [PW-1:0]   pick;
  logic [PW-1:0]   sel_inc;
  logic            found;
  logic            done_q;
  logic            done_rise;
  logic            timeout;
  logic [NREQ-1:0] pick_oh;
  logic [NREQ-1:0] sel_oh;
  logic [SIZE-1:0] words [NREQ];

  always_comb begin
    for (int i = 0; i < NREQ; i++) begin
      words[i] = ReqData[i*SIZE +: SIZE];
    end
  end

  // Scan from ptr upward; iterate backwards so the nearest index wins.
  always_comb begin
    int            j;
    logic [PW-1:0] idx;
    j     = 0;
    idx   = '0;
    found = 1'b0;
    pick  = '0;
    for (int k = NREQ-1; k >= 0; k--) begin
      j = int'(ptr) + k;
      if (j >= NREQ) j = j - NREQ;
      idx = PW'(j);
      if (Req[idx]) begin
        found = 1'b1;
        pick  = idx;
      end
    end
  end

  assign sel_inc   = (sel == PW'(NREQ-1)) ? '0 : sel + 1'b1;
  assign pick_oh   = NREQ'(1) << pick;
  assign sel_oh    = NREQ'(1) << sel;
  // Only a fresh edge counts: DoneTx may still be high from the last frame.
  assign done_rise = DoneTx & ~done_q;

  always_ff @(posedge CLK_Baudin) begin
    if (RstArb) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:      if (found) state_nxt = WAIT_DONE;
      WAIT_DONE: if (done_rise || timeout) state_nxt = RELEASE;
      RELEASE:   state_nxt = IDLE;
      default:   state_nxt = IDLE;
    endcase
  end

  always_comb begin
    Busy = (state != IDLE);
  end

  always_ff @(posedge CLK_Baudin) begin
    if (RstArb) begin
      Gnt       <= '0;
      Ack       <= '0;
      TxData    <= '0;
      TxNewData <= 1'b0;
      ptr       <= '0;
      sel       <= '0;
      done_q    <= 1'b0;
    end else begin
      done_q <= DoneTx;
      unique case (state)
        IDLE: begin
          if (found) begin
            Gnt       <= pick_oh;
            TxData    <= words[pick];
            TxNewData <= 1'b1;
            sel       <= pick;
          end
        end
        WAIT_DONE: begin
          TxNewData <= 1'b0;
          if (done_rise) Ack <= sel_oh;
          if (done_rise || timeout) ptr <= sel_inc;
        end
        RELEASE: begin
          Ack <= '0;
          Gnt <= '0;
        end
        default: ;
      endcase
    end
  end

`ifdef UART_TX_ARB_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT+1);

  logic [TW-1:0] timer;

  assign timeout = (timer == TW'(TIMEOUT-1));

  always_ff @(posedge CLK_Baudin) begin
    if (RstArb) begin
      timer <= '0;
      Err   <= '0;
      TxRst <= 1'b0;
    end else begin
      unique case (state)
        IDLE: if (found) timer <= '0;
        WAIT_DONE: begin
          if (timer != TW'(TIMEOUT)) timer <= timer + 1'b1;
          // A completion in the timeout cycle still counts as success.
          if (timeout && !done_rise) begin
            Err   <= sel_oh;
            TxRst <= 1'b1;
          end
        end
        RELEASE: begin
          Err   <= '0;
          TxRst <= 1'b0;
        end
        default: ;
      endcase
    end
  end
`else
  logic unused_timeout;

  assign unused_timeout = ^TIMEOUT;
  assign timeout        = 1'b0;
  assign Err            = '0;
  assign TxRst          = 1'b0;
`endif

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb_uart_tx_arbiter: scoreboard bench for uart_tx_arbiter with a
// behavioural transmitter (parity retries, stale DoneTx, TxRst abort).
module tb_uart_tx_arbiter;

  localparam int SIZE = 32;
  localparam int NREQ = 4;
  localparam int FR   = SIZE + 4;

  typedef struct {
    logic [3:0]  gnt;
    logic [31:0] data;
    bit          err;
    int          lat;
    int          gap;
  } exp_t;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [3:0]   req = '0;
  logic [127:0] req_data;
  logic [3:0]   gnt;
  logic [3:0]   ack;
  logic [3:0]   err;
  logic         busy;
  logic [31:0]  tx_data;
  logic         tx_new_data;
  logic         tx_rst;
  logic         done_tx = 1'b0;

  logic [31:0]  wd [4];
  exp_t         exp_q [$];
  int           n_chk = 0;
  int           n_err = 0;
  int           cyc = 0;
  int           nd_cyc = 0;
  int           last_end = 0;
  bit           post = 0;
  int           rearm [4];
  logic [3:0]   reraise = '0;
  int           t_tx = 0;
  bit           tx_active = 0;
  int           flag = 0;

  uart_tx_arbiter dut (
    .CLK_Baudin(clk),
    .RstArb(rst),
    .Req(req),
    .ReqData(req_data),
    .Gnt(gnt),
    .Ack(ack),
    .Err(err),
    .Busy(busy),
    .TxData(tx_data),
    .TxNewData(tx_new_data),
    .TxRst(tx_rst),
    .DoneTx(done_tx)
  );

  initial forever #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] want);
    n_chk++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, want);
    end
  endtask

  task automatic push(input logic [3:0] g, input logic [31:0] d,
                      input bit e, input int lat, input int gap);
    exp_t x;
    x.gnt  = g;
    x.data = d;
    x.err  = e;
    x.lat  = lat;
    x.gap  = gap;
    exp_q.push_back(x);
  endtask

  task automatic monitor();
    exp_t x;
    if (rst) return;
    if (tx_new_data) begin
      if (exp_q.size() == 0) begin
        chk("unexp_grant", {28'd0, gnt}, 64'd0);
      end else begin
        x = exp_q[0];
        chk("grant", {28'd0, gnt}, {28'd0, x.gnt});
        chk("txdata", {32'd0, tx_data}, {32'd0, x.data});
        if (x.gap != 0) chk("gap", cyc - last_end, x.gap);
        nd_cyc = cyc;
      end
    end
    if (|ack || |err) begin
      if (exp_q.size() == 0) begin
        chk("unexp_end", {56'd0, ack, err}, 64'd0);
      end else begin
        x = exp_q.pop_front();
        chk("ack", {60'd0, ack}, x.err ? 64'd0 : {60'd0, x.gnt});
        chk("err", {60'd0, err}, x.err ? {60'd0, x.gnt} : 64'd0);
        chk("txrst", {63'd0, tx_rst}, {63'd0, x.err});
        chk("busy_end", {63'd0, busy}, 64'd1);
        if (x.lat != 0) chk("latency", cyc - nd_cyc, x.lat);
      end
      last_end = cyc;
      post     = 1;
    end else if (post) begin
      chk("busy_after", {63'd0, busy}, 64'd0);
      chk("gnt_after", {60'd0, gnt}, 64'd0);
      post = 0;
    end
  endtask

  task automatic requester();
    logic [3:0] drop;
    drop    = ack | err;
    req     = (req & ~drop) | reraise;
    reraise = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (drop[i] && rearm[i] > 0) begin
        rearm[i]--;
        reraise[i] = 1'b1;
      end
    end
  endtask

  task automatic txmodel();
    if (rst || tx_rst) begin
      tx_active = 0;
      done_tx   = 1'b0;
      flag      = 0;
    end else if (tx_new_data) begin
      tx_active = 1;
      t_tx      = 0;
    end else if (tx_active) begin
      t_tx++;
      if (t_tx == 2) done_tx = 1'b0;
      if (flag >= 0 && t_tx == 2 + FR * (flag + 1)) begin
        done_tx   = 1'b1;
        tx_active = 0;
        flag      = 0;
      end
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
    monitor();
    requester();
    txmodel();
  endtask

  task automatic do_reset(input bit keep);
    rst = 1'b1;
    if (!keep) req = '0;
    for (int i = 0; i < NREQ; i++) rearm[i] = 0;
    reraise = '0;
    step();
    chk("rst_gnt", {60'd0, gnt}, 64'd0);
    chk("rst_ack", {60'd0, ack}, 64'd0);
    chk("rst_err", {60'd0, err}, 64'd0);
    chk("rst_busy", {63'd0, busy}, 64'd0);
    chk("rst_txdata", {32'd0, tx_data}, 64'd0);
    chk("rst_newdata", {63'd0, tx_new_data}, 64'd0);
    chk("rst_txrst", {63'd0, tx_rst}, 64'd0);
    rst = 1'b0;
    exp_q.delete();
    post = 0;
  endtask

  task automatic drain(input int limit);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < limit) begin
      step();
      n++;
    end
    if (exp_q.size() != 0) begin
      chk("drain_timeout", exp_q.size(), 64'd0);
      exp_q.delete();
    end
    step();
  endtask

  initial begin
    int bb;
    int be;
    wd[0] = 32'hA5A5_0F0F;
    wd[1] = 32'h1234_5678;
    wd[2] = 32'hDEAD_BEEF;
    wd[3] = 32'h0BAD_F00D;
    req_data = {wd[3], wd[2], wd[1], wd[0]};

    do_reset(0);

    req = 4'b0001;
    push(4'b0001, wd[0], 0, 39, 0);
    step();
    chk("t1_newdata_lat", {63'd0, tx_new_data}, 64'd1);
    chk("t1_txdata", {32'd0, tx_data}, {32'd0, wd[0]});
    step();
    chk("t1_newdata_pulse", {63'd0, tx_new_data}, 64'd0);
    chk("t1_gnt_hold", {60'd0, gnt}, 64'd1);
    drain(200);

    do_reset(0);
    req      = 4'b1111;
    rearm[0] = 1;
    push(4'b0001, wd[0], 0, 39, 0);
    push(4'b0010, wd[1], 0, 39, 2);
    push(4'b0100, wd[2], 0, 39, 2);
    push(4'b1000, wd[3], 0, 39, 2);
    push(4'b0001, wd[0], 0, 39, 2);
    drain(1000);

    do_reset(0);
    req = 4'b0010;
    push(4'b0010, wd[1], 0, 39, 0);
    drain(200);
    chk("t3_stale_high", {63'd0, done_tx}, 64'd1);
    req = 4'b0100;
    push(4'b0100, wd[2], 0, 39, 0);
    drain(200);

    do_reset(0);
    flag = 2;
    req  = 4'b1000;
    push(4'b1000, wd[3], 0, 111, 0);
    drain(400);

    do_reset(0);
    flag = -1;
`ifdef UART_TX_ARB_TIMEOUT_EN
    req = 4'b0011;
    push(4'b0001, wd[0], 1, 140, 0);
    push(4'b0010, wd[1], 0, 39, 2);
    drain(600);
`else
    req = 4'b0001;
    push(4'b0001, wd[0], 0, 0, 0);
    step();
    step();
    bb = 0;
    be = 0;
    repeat (300) begin
      step();
      if (!busy) bb++;
      if (err != 4'b0000) be++;
    end
    chk("t5_busy_hold", bb, 64'd0);
    chk("t5_no_err", be, 64'd0);
    chk("t5_gnt_hold", {60'd0, gnt}, 64'd1);
`endif

    do_reset(0);
    req = 4'b0010;
    push(4'b0010, wd[1], 0, 39, 0);
    drain(200);
    req = 4'b1001;
    push(4'b1000, wd[3], 0, 0, 0);
    repeat (10) step();
    chk("t6_busy_mid", {63'd0, busy}, 64'd1);
    chk("t6_gnt_mid", {60'd0, gnt}, 64'h8);
    do_reset(1);
    push(4'b0001, wd[0], 0, 39, 0);
    push(4'b1000, wd[3], 0, 39, 2);
    drain(400);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
